// File: rtl/prf_pkg.sv
// Shared types and default sizing for the multiport physical register file.
package prf_pkg;

  localparam int DEF_NUM_ENTRIES = 64;
  localparam int DEF_XLEN        = 32;
  localparam int DEF_RD_PORTS    = 4;
  localparam int DEF_WR_PORTS    = 2;

  typedef enum logic {
    RD_LAT_COMB = 1'b0,
    RD_LAT_REG  = 1'b1
  } rd_latency_e;

  localparam rd_latency_e DEF_READ_LATENCY = RD_LAT_COMB;

  typedef struct packed {
    logic [DEF_XLEN-1:0] value;
    logic                ready;
  } PRF_ENTRY;

  function automatic logic is_registered(input int latency);
    return latency == int'(RD_LAT_REG);
  endfunction

endpackage

// File: rtl/prf_read_port.sv
// One PRF read port: write bypass, tag fallback when not ready, optional output register.
module prf_read_port
  import prf_pkg::*;
#(
  parameter int XLEN         = DEF_XLEN,
  parameter int IDX          = 6,
  parameter int WR_PORTS     = DEF_WR_PORTS,
  parameter int READ_LATENCY = int'(DEF_READ_LATENCY)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rd_en_i,
  input  logic [IDX-1:0]           rd_idx_i,
  input  logic [XLEN-1:0]          stored_val_i,
  input  logic                     stored_rdy_i,
  input  logic                     clr_i,
  input  logic [WR_PORTS-1:0]      wr_en_i,
  input  logic [WR_PORTS*IDX-1:0]  wr_idx_i,
  input  logic [WR_PORTS*XLEN-1:0] wr_val_i,
  output logic                     rd_valid_o,
  output logic [XLEN-1:0]          rd_val_o,
  output logic                     rd_ready_o
);

  logic            hit;
  logic            use_byp;
  logic [XLEN-1:0] byp_val;
  logic [XLEN-1:0] res_val;
  logic            res_rdy;

  // Highest-numbered matching write port wins; entry 0 never bypasses.
  always_comb begin
    hit     = 1'b0;
    byp_val = '0;
    for (int w = 0; w < WR_PORTS; w++) begin
      if (wr_en_i[w] && (wr_idx_i[w*IDX +: IDX] == rd_idx_i) && (rd_idx_i != '0)) begin
        hit     = 1'b1;
        byp_val = wr_val_i[w*XLEN +: XLEN];
      end
    end
    use_byp = hit && !clr_i;
    res_rdy = use_byp || stored_rdy_i;
    if (!res_rdy) begin
      res_val = {{(XLEN-IDX){1'b0}}, rd_idx_i};
    end else if (use_byp) begin
      res_val = byp_val;
    end else begin
      res_val = stored_val_i;
    end
  end

  generate
    if (is_registered(READ_LATENCY)) begin : g_reg
      logic            valid_q;
      logic [XLEN-1:0] val_q;
      logic            rdy_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          valid_q <= 1'b0;
          val_q   <= '0;
          rdy_q   <= 1'b0;
        end else begin
          valid_q <= rd_en_i;
          if (rd_en_i) begin
            val_q <= res_val;
            rdy_q <= res_rdy;
          end
        end
      end

      assign rd_valid_o = valid_q;
      assign rd_val_o   = val_q;
      assign rd_ready_o = rdy_q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clock ^ reset;

      assign rd_valid_o = rd_en_i;
      assign rd_val_o   = res_val;
      assign rd_ready_o = res_rdy;
    end
  endgenerate

endmodule

// File: rtl/prf_multiport.sv
// Physical register file with ready scoreboard, CDB write ports, alloc/free clears
// and sticky same-entry multi-write detection.
module prf_multiport
  import prf_pkg::*;
#(
  parameter  int NUM_ENTRIES  = DEF_NUM_ENTRIES,
  parameter  int XLEN         = DEF_XLEN,
  parameter  int RD_PORTS     = DEF_RD_PORTS,
  parameter  int WR_PORTS     = DEF_WR_PORTS,
  parameter  int READ_LATENCY = int'(DEF_READ_LATENCY),
  localparam int IDX          = $clog2(NUM_ENTRIES)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [RD_PORTS-1:0]      rd_en_i,
  input  logic [RD_PORTS*IDX-1:0]  rd_idx_i,
  output logic [RD_PORTS-1:0]      rd_valid_o,
  output logic [RD_PORTS*XLEN-1:0] rd_val_o,
  output logic [RD_PORTS-1:0]      rd_ready_o,
  input  logic [WR_PORTS-1:0]      wr_en_i,
  input  logic [WR_PORTS*IDX-1:0]  wr_idx_i,
  input  logic [WR_PORTS*XLEN-1:0] wr_val_i,
  input  logic [NUM_ENTRIES-1:0]   alloc_vec_i,
  input  logic [NUM_ENTRIES-1:0]   free_vec_i,
  output logic                     err_multi_write_o,
  output logic [NUM_ENTRIES-1:0]   ready_vec_o
);

  logic [XLEN-1:0]        value_q [NUM_ENTRIES];
  logic [XLEN-1:0]        value_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] ready_q;
  logic [NUM_ENTRIES-1:0] ready_d;
  logic [NUM_ENTRIES-1:0] clr_vec;
  logic                   err_q;
  logic                   err_d;
  logic                   collision;

  assign clr_vec = alloc_vec_i | free_vec_i;

  // Writes in port order, then alloc/free clears override any ready set here.
  always_comb begin
    value_d = value_q;
    ready_d = ready_q;
    for (int w = 0; w < WR_PORTS; w++) begin
      if (wr_en_i[w] && (wr_idx_i[w*IDX +: IDX] != '0)) begin
        value_d[wr_idx_i[w*IDX +: IDX]] = wr_val_i[w*XLEN +: XLEN];
        ready_d[wr_idx_i[w*IDX +: IDX]] = 1'b1;
      end
    end
    ready_d    = ready_d & ~clr_vec;
    ready_d[0] = 1'b1;
    value_d[0] = '0;
  end

  always_comb begin
    collision = 1'b0;
    for (int i = 0; i < WR_PORTS; i++) begin
      for (int j = i + 1; j < WR_PORTS; j++) begin
        if (wr_en_i[i] && wr_en_i[j] &&
            (wr_idx_i[i*IDX +: IDX] == wr_idx_i[j*IDX +: IDX]) &&
            (wr_idx_i[i*IDX +: IDX] != '0)) begin
          collision = 1'b1;
        end
      end
    end
    err_d = err_q || collision;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        value_q[e] <= '0;
      end
      ready_q <= NUM_ENTRIES'(1);
      err_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign err_multi_write_o = err_q;
  assign ready_vec_o       = ready_q;

  generate
    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
      logic [IDX-1:0] idx;
      assign idx = rd_idx_i[p*IDX +: IDX];

      prf_read_port #(
        .XLEN        (XLEN),
        .IDX         (IDX),
        .WR_PORTS    (WR_PORTS),
        .READ_LATENCY(READ_LATENCY)
      ) u_rd (
        .clock       (clock),
        .reset       (reset),
        .rd_en_i     (rd_en_i[p]),
        .rd_idx_i    (idx),
        .stored_val_i(value_q[idx]),
        .stored_rdy_i(ready_q[idx]),
        .clr_i       (clr_vec[idx]),
        .wr_en_i     (wr_en_i),
        .wr_idx_i    (wr_idx_i),
        .wr_val_i    (wr_val_i),
        .rd_valid_o  (rd_valid_o[p]),
        .rd_val_o    (rd_val_o[p*XLEN +: XLEN]),
        .rd_ready_o  (rd_ready_o[p])
      );
    end
  endgenerate

endmodule

// File: tb/tb_prf_multiport.sv
// Scoreboard bench: one combinational-read and one registered-read PRF driven in lockstep.
module tb_prf_multiport;

  localparam int N    = 64;
  localparam int XLEN = 32;
  localparam int RP   = 4;
  localparam int WP   = 2;
  localparam int IDX  = 6;

  logic              clock = 1'b0;
  logic              reset;
  logic [RP-1:0]     rd_en;
  logic [RP*IDX-1:0] rd_idx;
  logic [WP-1:0]     wr_en;
  logic [WP*IDX-1:0] wr_idx;
  logic [WP*XLEN-1:0] wr_val;
  logic [N-1:0]      alloc_vec;
  logic [N-1:0]      free_vec;

  logic [RP-1:0]      d0_valid, d1_valid;
  logic [RP*XLEN-1:0] d0_val, d1_val;
  logic [RP-1:0]      d0_rdy, d1_rdy;
  logic               d0_err, d1_err;
  logic [N-1:0]       d0_rvec, d1_rvec;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  prf_multiport #(.NUM_ENTRIES(N), .XLEN(XLEN), .RD_PORTS(RP), .WR_PORTS(WP), .READ_LATENCY(0)) u_d0 (
    .clock(clock), .reset(reset), .rd_en_i(rd_en), .rd_idx_i(rd_idx),
    .rd_valid_o(d0_valid), .rd_val_o(d0_val), .rd_ready_o(d0_rdy),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_val_i(wr_val),
    .alloc_vec_i(alloc_vec), .free_vec_i(free_vec),
    .err_multi_write_o(d0_err), .ready_vec_o(d0_rvec));

  prf_multiport #(.NUM_ENTRIES(N), .XLEN(XLEN), .RD_PORTS(RP), .WR_PORTS(WP), .READ_LATENCY(1)) u_d1 (
    .clock(clock), .reset(reset), .rd_en_i(rd_en), .rd_idx_i(rd_idx),
    .rd_valid_o(d1_valid), .rd_val_o(d1_val), .rd_ready_o(d1_rdy),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_val_i(wr_val),
    .alloc_vec_i(alloc_vec), .free_vec_i(free_vec),
    .err_multi_write_o(d1_err), .ready_vec_o(d1_rvec));

  typedef struct packed {
    logic               rst;
    logic [RP-1:0]      en;
    logic [RP-1:0]      rdy;
    logic [RP*XLEN-1:0] val;
  } exp_t;

  exp_t sb_q[$];

  logic [XLEN-1:0]    m_val [N];
  logic [N-1:0]       m_rdy;
  logic               m_err;
  logic [RP*XLEN-1:0] h_val;
  logic [RP-1:0]      h_rdy;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_read(input logic [IDX-1:0] idx, output logic [XLEN-1:0] v, output logic r);
    logic            hit;
    logic [XLEN-1:0] bv;
    hit = 1'b0;
    bv  = '0;
    if (idx == '0) begin
      v = '0;
      r = 1'b1;
    end else begin
      for (int w = 0; w < WP; w++) begin
        if (wr_en[w] && wr_idx[w*IDX +: IDX] == idx) begin
          hit = 1'b1;
          bv  = wr_val[w*XLEN +: XLEN];
        end
      end
      if (hit && !(alloc_vec[idx] || free_vec[idx])) begin
        v = bv;
        r = 1'b1;
      end else begin
        v = m_val[idx];
        r = m_rdy[idx];
      end
      if (!r) v = XLEN'(idx);
    end
  endtask

  task automatic model_update();
    logic [IDX-1:0] wi;
    if (reset) begin
      for (int e = 0; e < N; e++) m_val[e] = '0;
      m_rdy = N'(1);
      m_err = 1'b0;
    end else begin
      for (int w = 0; w < WP; w++) begin
        wi = wr_idx[w*IDX +: IDX];
        if (wr_en[w] && wi != '0) begin
          m_val[wi] = wr_val[w*XLEN +: XLEN];
          m_rdy[wi] = 1'b1;
        end
      end
      for (int i = 0; i < WP; i++)
        for (int j = i + 1; j < WP; j++)
          if (wr_en[i] && wr_en[j] && wr_idx[i*IDX +: IDX] == wr_idx[j*IDX +: IDX] &&
              wr_idx[i*IDX +: IDX] != '0)
            m_err = 1'b1;
      m_rdy    = m_rdy & ~(alloc_vec | free_vec);
      m_rdy[0] = 1'b1;
    end
  endtask

  // One clock: check mode-0 outputs, queue mode-1 expectations, advance, check mode-1 and state.
  task automatic cyc();
    exp_t            e;
    logic [XLEN-1:0] v;
    logic            r;
    #1;
    e     = '0;
    e.rst = reset;
    e.en  = rd_en;
    for (int p = 0; p < RP; p++) begin
      model_read(rd_idx[p*IDX +: IDX], v, r);
      e.val[p*XLEN +: XLEN] = v;
      e.rdy[p]              = r;
      check_eq("m0_valid", 128'(d0_valid[p]), 128'(rd_en[p]));
      if (!reset && rd_en[p]) begin
        check_eq("m0_val", 128'(d0_val[p*XLEN +: XLEN]), 128'(v));
        check_eq("m0_rdy", 128'(d0_rdy[p]), 128'(r));
      end
    end
    sb_q.push_back(e);
    @(posedge clock);
    model_update();
    #1;
    e = sb_q.pop_front();
    if (e.rst) begin
      h_val = '0;
      h_rdy = '0;
    end else begin
      for (int p = 0; p < RP; p++) begin
        if (e.en[p]) begin
          h_val[p*XLEN +: XLEN] = e.val[p*XLEN +: XLEN];
          h_rdy[p]              = e.rdy[p];
        end
      end
    end
    check_eq("m1_valid", 128'(d1_valid), e.rst ? 128'(0) : 128'(e.en));
    check_eq("m1_val", 128'(d1_val), 128'(h_val));
    check_eq("m1_rdy", 128'(d1_rdy), 128'(h_rdy));
    check_eq("ready_vec0", 128'(d0_rvec), 128'(m_rdy));
    check_eq("ready_vec1", 128'(d1_rvec), 128'(m_rdy));
    check_eq("err0", 128'(d0_err), 128'(m_err));
    check_eq("err1", 128'(d1_err), 128'(m_err));
  endtask

  task automatic idle();
    rd_en = '0; rd_idx = '0; wr_en = '0; wr_idx = '0; wr_val = '0;
    alloc_vec = '0; free_vec = '0;
  endtask

  task automatic set_rd(input int p, input int idx);
    rd_en[p]            = 1'b1;
    rd_idx[p*IDX +: IDX] = IDX'(idx);
  endtask

  task automatic set_wr(input int w, input int idx, input logic [XLEN-1:0] v);
    wr_en[w]                = 1'b1;
    wr_idx[w*IDX +: IDX]     = IDX'(idx);
    wr_val[w*XLEN +: XLEN]   = v;
  endtask

  initial begin
    for (int e = 0; e < N; e++) m_val[e] = '0;
    m_rdy = N'(1);
    m_err = 1'b0;
    h_val = '0;
    h_rdy = '0;
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;

    // Fresh state: idx 5 reads as tag, idx 0 reads as ready zero.
    set_rd(0, 5); set_rd(1, 0); set_rd(2, 7); set_rd(3, 9);
    cyc();
    check_eq("tp_tag5", 128'(d1_val[31:0]), 128'(5));

    // Same-cycle bypass of a port-1 write.
    idle(); set_rd(0, 7); set_wr(1, 7, 32'hDEAD_BEEF);
    cyc();
    check_eq("tp_byp_m1", 128'(d1_val[31:0]), 128'(32'hDEAD_BEEF));
    idle(); set_rd(2, 7);
    cyc();

    // Two ports on one entry: higher port wins, error is sticky.
    idle(); set_wr(0, 9, 32'h11); set_wr(1, 9, 32'h22);
    cyc();
    check_eq("tp_err_set", 128'(d0_err), 128'(1));
    idle(); set_rd(1, 9);
    cyc();
    check_eq("tp_win", 128'(d0_val[63:32]), 128'(32'h22));
    idle();
    cyc();
    check_eq("tp_err_hold", 128'(d1_err), 128'(1));

    // Write with a same-cycle free leaves the entry not ready.
    idle(); set_wr(0, 12, 32'hABCD); free_vec[12] = 1'b1; set_rd(3, 12);
    cyc();
    check_eq("tp_free12", 128'(d0_rvec[12]), 128'(0));
    idle(); set_rd(3, 12);
    cyc();

    // Entry 0 ignores writes.
    idle(); set_wr(1, 0, 32'hFFFF_FFFF); set_rd(0, 0);
    cyc();
    idle(); set_rd(0, 0); alloc_vec[0] = 1'b1;
    cyc();

    // Alloc clears a previously ready entry.
    idle(); set_wr(0, 20, 32'h1234_5678);
    cyc();
    idle(); set_rd(1, 20); alloc_vec[20] = 1'b1; set_wr(1, 20, 32'h55);
    cyc();
    idle(); set_rd(1, 20);
    cyc();

    // Random traffic over a narrow index range to exercise bypass, collisions and holds.
    for (int c = 0; c < 300; c++) begin
      idle();
      rd_en = RP'($urandom);
      for (int p = 0; p < RP; p++) rd_idx[p*IDX +: IDX] = IDX'($urandom_range(0, 15));
      for (int w = 0; w < WP; w++) begin
        wr_en[w]              = 1'($urandom);
        wr_idx[w*IDX +: IDX]   = IDX'($urandom_range(0, 15));
        wr_val[w*XLEN +: XLEN] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) alloc_vec[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) free_vec[$urandom_range(0, 15)] = 1'b1;
      cyc();
    end

    // Reset during a registered read drops it.
    idle(); set_rd(0, 0); set_rd(1, 3); reset = 1'b1;
    cyc();
    check_eq("tp_rst_valid", 128'(d1_valid), 128'(0));
    check_eq("tp_rst_val", 128'(d1_val), 128'(0));
    reset = 1'b0;
    idle(); set_rd(0, 9);
    cyc();
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
